// File: rtl/sloth_program_executor.sv
// Sequential evaluator for encoded sloth_pid register programs: loads four operands,
// executes one streamed instruction per cycle on r0..r3 and returns the final registers.
module sloth_program_executor #(
    parameter int DATA_W    = 16,
    parameter int MAX_INSTR = 64,
    parameter int CNT_W     = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b1,
    input  logic [DATA_W-1:0] b0,
    input  logic              instr_valid,
    input  logic [7:0]        instr,
    output logic              instr_ready,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    output logic [DATA_W-1:0] y3,
    output logic [DATA_W-1:0] y2,
    output logic [DATA_W-1:0] y1,
    output logic [DATA_W-1:0] y0
);

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, DONE} state_t;
    typedef enum logic [2:0] {
        OP_XOR, OP_AND, OP_OR, OP_LNOT, OP_MOV, OP_BNOT, OP_NOP, OP_END
    } opcode_t;

    state_t            state;
    logic [DATA_W-1:0] regs [4];
    logic [DATA_W-1:0] nxt  [4];
    logic [DATA_W-1:0] op_a1, op_a0, op_b1, op_b0;
    logic [CNT_W-1:0]  cnt;

    opcode_t           op;
    logic [1:0]        dst;
    logic [2:0]        src;
    logic [DATA_W-1:0] src_val;
    logic [DATA_W-1:0] dst_val;
    logic [DATA_W-1:0] result;
    logic              last_slot;

    assign op        = opcode_t'(instr[7:5]);
    assign dst       = instr[4:3];
    assign src       = instr[2:0];
    assign last_slot = (cnt == CNT_W'(MAX_INSTR - 1));

    // Next register file for the presented instruction; reads use pre-instruction values.
    always_comb begin
        src_val = '0;
        case (src)
            3'd0: src_val = regs[0];
            3'd1: src_val = regs[1];
            3'd2: src_val = regs[2];
            3'd3: src_val = regs[3];
            3'd4: src_val = op_a0;
            3'd5: src_val = op_a1;
            3'd6: src_val = op_b0;
            default: src_val = op_b1;
        endcase
        dst_val = regs[dst];
        result  = dst_val;
        case (op)
            OP_XOR:  result = dst_val ^ src_val;
            OP_AND:  result = dst_val & src_val;
            OP_OR:   result = dst_val | src_val;
            OP_LNOT: result = (src_val == '0) ? DATA_W'(1) : '0;
            OP_MOV:  result = src_val;
            OP_BNOT: result = ~src_val;
            default: result = dst_val;
        endcase
        for (int i = 0; i < 4; i++) begin
            nxt[i] = (dst == 2'(i)) ? result : regs[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            op_a1       <= '0;
            op_a0       <= '0;
            op_b1       <= '0;
            op_b0       <= '0;
            cnt         <= '0;
            y3          <= '0;
            y2          <= '0;
            y1          <= '0;
            y0          <= '0;
            instr_ready <= 1'b0;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a1 <= a1;
                        op_a0 <= a0;
                        op_b1 <= b1;
                        op_b0 <= b0;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    regs[0]     <= op_a0;
                    regs[1]     <= op_a1;
                    regs[2]     <= op_b0;
                    regs[3]     <= op_b1;
                    cnt         <= '0;
                    instr_ready <= 1'b1;
                    state       <= EXEC;
                end
                EXEC: begin
                    if (instr_valid) begin
                        if (op == OP_END) begin
                            y3          <= regs[3];
                            y2          <= regs[2];
                            y1          <= regs[1];
                            y0          <= regs[0];
                            overflow    <= 1'b0;
                            out_valid   <= 1'b1;
                            instr_ready <= 1'b0;
                            state       <= DONE;
                        end else begin
                            for (int i = 0; i < 4; i++) regs[i] <= nxt[i];
                            cnt <= cnt + CNT_W'(1);
                            // The budget-exhausting instruction still lands in the outputs.
                            if (last_slot) begin
                                y3          <= nxt[3];
                                y2          <= nxt[2];
                                y1          <= nxt[1];
                                y0          <= nxt[0];
                                overflow    <= 1'b1;
                                out_valid   <= 1'b1;
                                instr_ready <= 1'b0;
                                state       <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        overflow  <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
